uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters sharing the UART transmitter (legal 2..8).
REQ-002 Parameter MAXLEN, default 16, maximum bytes per grant before forced release (legal 1..255).
REQ-003 CLK  input  1  master clock; all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous assertion, active-high.
REQ-005 REQ_VALID  input  NREQ  per-requester byte valid.
REQ-006 REQ_DATA  input  8*NREQ  per-requester byte; requester i in bits [8i+7:8i].
REQ-007 REQ_LAST  input  NREQ  per-requester end-of-frame, qualified by its valid.
REQ-008 REQ_READY  output  NREQ  per-requester accept.
REQ-009 TX_VALID  output  1  byte available to transmitter.
REQ-010 TX_DATA  output  8  byte to transmitter.
REQ-011 TX_READY  input  1  transmitter accepts TX_DATA this cycle.
REQ-012 GRANT  output  NREQ  one-hot current owner, all-zero when idle.
REQ-013 BUSY  output  1  high when state is LOCKED or the output register is full.

Function
REQ-014 Handshake transfer occurs on any rising edge with VALID and READY both high; data held stable while VALID high and READY low.
REQ-015 States: IDLE, LOCKED; encoding free.
REQ-016 IDLE: any REQ_VALID high -> select first requester with valid in order ptr+1, ptr+2, ... mod NREQ; next cycle LOCKED, GRANT one-hot on owner, byte counter cleared.
REQ-017 IDLE: REQ_READY all zero; no byte accepted in the arbitration cycle.
REQ-018 LOCKED: REQ_READY[owner] = ~out_full | TX_READY; all other REQ_READY bits zero.
REQ-019 Owner transfer loads REQ_DATA[owner] into output register; out_full set; byte counter increments (8 bits).
REQ-020 Output register: TX_VALID = out_full, TX_DATA = register; TX_READY with out_full and no load clears out_full; simultaneous load and drain keeps out_full high with new byte (no bubble, one byte per cycle sustained).
REQ-021 Owner transfer with REQ_LAST high, or with counter reaching MAXLEN on that transfer, -> IDLE next cycle, GRANT cleared, ptr <= owner.
REQ-022 Owner dropping REQ_VALID without LAST keeps the grant; no timeout.
REQ-023 Return to IDLE with out_full still high is legal; pending byte drains normally while next arbitration proceeds.
REQ-024 Latency: first REQ_VALID in IDLE to first REQ_READY = 1 cycle; accepted byte to TX_VALID = 1 cycle.
REQ-025 Non-owner REQ_VALID/REQ_DATA/REQ_LAST ignored; bytes never reordered or duplicated within a frame.
REQ-026 GRANT, REQ_READY and TX_VALID never X after reset; GRANT at most one bit high.

Reset
REQ-027 RST high asynchronously forces: state IDLE, GRANT 0, REQ_READY 0, TX_VALID 0, TX_DATA 8'h00, out_full 0, counter 0, ptr NREQ-1 (requester 0 highest priority first).
REQ-028 RST mid-frame discards the held output byte and the partial frame; no further transfer until RST low and a fresh arbitration.
REQ-029 Outputs stable at reset values while RST high regardless of inputs.

Verification
REQ-030 Single frame: req 2 sends 8'h41,8'h42,8'h43(LAST), TX_READY=1 -> TX_DATA 41,42,43 on consecutive cycles, GRANT=4'b0100 throughout, then GRANT=0.
REQ-031 Round-robin: all 4 requesters continuously valid with 1-byte LAST frames -> grant order 0,1,2,3,0 after reset.
REQ-032 Backpressure: TX_READY low 5 cycles during frame -> TX_VALID held, TX_DATA unchanged, owner REQ_READY low, no byte lost when TX_READY returns.
REQ-033 Forced release: MAXLEN=4, req 1 streams 6 bytes no LAST, req 3 waiting -> 4 bytes from req 1, then req 3 granted, then req 1 resumes byte 5.
REQ-034 Reset mid-frame: RST pulse after 2nd byte of a 5-byte frame -> TX_VALID and GRANT 0 same cycle RST rises; after release, req 0 wins if valid.
REQ-035 Arbitration skew: req 1 and req 2 raise valid in same cycle with ptr=1 -> req 2 granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ byte requesters share one UART transmitter, a frame at a time.
// Latency: 1 cycle from IDLE request to ready; 1 cycle from accepted byte to TX_VALID; 1 byte/cycle sustained.
// Backpressure: the owner's REQ_READY follows ~out_full | TX_READY; all other requesters wait until the grant is released.
module uart_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int MAXLEN = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ_VALID,
    input  logic [8*NREQ-1:0]   REQ_DATA,
    input  logic [NREQ-1:0]     REQ_LAST,
    output logic [NREQ-1:0]     REQ_READY,
    output logic                TX_VALID,
    output logic [7:0]          TX_DATA,
    input  logic                TX_READY,
    output logic [NREQ-1:0]     GRANT,
    output logic                BUSY
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [7:0]      cnt;
    logic [7:0]      cnt_nxt;
    logic [7:0]      out_dat;
    logic            out_full;
    logic            owner_vld;
    logic            owner_last;
    logic [7:0]      owner_dat;
    logic            owner_rdy;
    logic            xfer;
    logic            release_now;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        return IW'((int'(base) + k) % NREQ);
    endfunction

    // Scan from the farthest candidate down so the nearest valid requester after ptr wins.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (REQ_VALID[rr_idx(ptr, k)]) begin
                pick     = rr_idx(ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    assign owner_vld   = REQ_VALID[owner];
    assign owner_last  = REQ_LAST[owner];
    assign owner_dat   = REQ_DATA[{owner, 3'b000} +: 8];
    assign owner_rdy   = (state == LOCKED) && (!out_full || TX_READY);
    assign xfer        = owner_rdy && owner_vld;
    assign cnt_nxt     = cnt + 8'd1;
    assign release_now = xfer && (owner_last || (cnt_nxt == 8'(MAXLEN)));

    always_comb begin
        REQ_READY = '0;
        if (owner_rdy) begin
            REQ_READY[owner] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= IW'(NREQ - 1);
            cnt      <= 8'd0;
            GRANT    <= '0;
            out_full <= 1'b0;
            out_dat  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= LOCKED;
                        owner <= pick;
                        GRANT <= NREQ'(1) << pick;
                        cnt   <= 8'd0;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        cnt <= cnt_nxt;
                    end
                    if (release_now) begin
                        state <= IDLE;
                        GRANT <= '0;
                        ptr   <= owner;
                    end
                end
                default: state <= IDLE;
            endcase

            // Load and drain in the same cycle keeps the register full, so there is no bubble.
            if (xfer) begin
                out_full <= 1'b1;
                out_dat  <= owner_dat;
            end else if (TX_READY) begin
                out_full <= 1'b0;
            end
        end
    end

    assign TX_VALID = out_full;
    assign TX_DATA  = out_dat;
    assign BUSY     = (state == LOCKED) || out_full;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, expected TX byte stream queued up front.
module tb_uart_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int MAXLEN = 4;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     REQ_VALID;
    logic [8*NREQ-1:0]   REQ_DATA;
    logic [NREQ-1:0]     REQ_LAST;
    logic [NREQ-1:0]     REQ_READY;
    logic                TX_VALID;
    logic [7:0]          TX_DATA;
    logic                TX_READY;
    logic [NREQ-1:0]     GRANT;
    logic                BUSY;

    logic [8:0]  src_mem [NREQ][64];
    int          src_rd  [NREQ];
    int          src_wr  [NREQ];
    logic [NREQ-1:0] en;
    logic [NREQ-1:0] acc;
    logic [7:0]  exp_q [$];

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_LAST  (REQ_LAST),
        .REQ_READY (REQ_READY),
        .TX_VALID  (TX_VALID),
        .TX_DATA   (TX_DATA),
        .TX_READY  (TX_READY),
        .GRANT     (GRANT),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            REQ_VALID[i]       = en[i] && (src_rd[i] != src_wr[i]);
            REQ_DATA[8*i +: 8] = src_mem[i][src_rd[i][5:0]][7:0];
            REQ_LAST[i]        = src_mem[i][src_rd[i][5:0]][8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_wr[r][5:0]] = {l, d};
        src_wr[r] = src_wr[r] + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #3;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    // Sources advance one entry after every accepted handshake.
    always @(posedge CLK) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) src_rd[i] = src_rd[i] + 1;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            acc = '0;
        end else begin
            acc = REQ_VALID & REQ_READY;
            check("grant_onehot", 32'($onehot0(GRANT)), 32'd1);
            if (TX_VALID && TX_READY) begin
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", 32'(TX_DATA), 32'h100);
                end else begin
                    check("tx_data", 32'(TX_DATA), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        TX_READY = 1'b0;
        en       = '1;
        acc      = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
            for (int j = 0; j < 64; j++) src_mem[i][j] = 9'h000;
        end

        // Outputs frozen at reset values while a requester is valid.
        tick(1);
        push(0, 8'hEE, 1'b1);
        for (int c = 0; c < 3; c++) begin
            TX_READY = ~TX_READY;
            tick(1);
            check("rst_grant", 32'(GRANT), 32'd0);
            check("rst_ready", 32'(REQ_READY), 32'd0);
            check("rst_txvalid", 32'(TX_VALID), 32'd0);
            check("rst_txdata", 32'(TX_DATA), 32'h00);
            check("rst_busy", 32'(BUSY), 32'd0);
        end
        src_rd[0] = src_wr[0];
        TX_READY  = 1'b1;
        RST       = 1'b0;

        // Single frame from requester 2.
        tick(1);
        push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        tick(1);
        check("sf_grant", 32'(GRANT), 32'b0100);
        check("sf_ready", 32'(REQ_READY), 32'b0100);
        check("sf_busy", 32'(BUSY), 32'd1);
        tick(1);
        check("sf_txvalid", 32'(TX_VALID), 32'd1);
        check("sf_tx0", 32'(TX_DATA), 32'h41);
        check("sf_grant_hold", 32'(GRANT), 32'b0100);
        tick(1);
        check("sf_tx1", 32'(TX_DATA), 32'h42);
        tick(1);
        check("sf_tx2", 32'(TX_DATA), 32'h43);
        check("sf_grant_clr", 32'(GRANT), 32'd0);
        wait_drain("frame");

        // Round robin from reset: 0,1,2,3,0.
        do_reset();
        push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1); push(0, 8'hA4, 1'b1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
        tick(1);
        check("rr_first", 32'(GRANT), 32'b0001);
        wait_drain("rr");

        // Backpressure: transmitter stalls 5 cycles after the first byte.
        push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b0); push(1, 8'h54, 1'b1);
        exp_q.push_back(8'h51); exp_q.push_back(8'h52); exp_q.push_back(8'h53); exp_q.push_back(8'h54);
        tick(1);
        check("bp_grant", 32'(GRANT), 32'b0010);
        tick(1);
        check("bp_tx0", 32'(TX_DATA), 32'h51);
        TX_READY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check("bp_txvalid", 32'(TX_VALID), 32'd1);
            check("bp_txdata", 32'(TX_DATA), 32'h51);
            check("bp_ready", 32'(REQ_READY), 32'd0);
        end
        TX_READY = 1'b1;
        wait_drain("bp");

        // Forced release after MAXLEN bytes lets requester 3 in.
        do_reset();
        push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b0);
        push(1, 8'h64, 1'b0); push(1, 8'h65, 1'b0); push(1, 8'h66, 1'b0);
        exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63); exp_q.push_back(8'h64);
        exp_q.push_back(8'h7F); exp_q.push_back(8'h65); exp_q.push_back(8'h66);
        tick(1);
        check("ml_grant", 32'(GRANT), 32'b0010);
        push(3, 8'h7F, 1'b1);
        wait_drain("maxlen");
        tick(2);
        check("ml_hold_grant", 32'(GRANT), 32'b0010);
        check("ml_hold_busy", 32'(BUSY), 32'd1);

        // Reset after the second byte of a 5-byte frame.
        do_reset();
        push(1, 8'h81, 1'b0); push(1, 8'h82, 1'b0); push(1, 8'h83, 1'b0);
        push(1, 8'h84, 1'b0); push(1, 8'h85, 1'b1);
        exp_q.push_back(8'h81);
        tick(3);
        check("mr_pre", 32'(TX_DATA), 32'h82);
        RST = 1'b1;
        #1;
        check("mr_txvalid", 32'(TX_VALID), 32'd0);
        check("mr_grant", 32'(GRANT), 32'd0);
        check("mr_ready", 32'(REQ_READY), 32'd0);
        check("mr_q", 32'(exp_q.size()), 32'd0);
        push(0, 8'h90, 1'b1);
        exp_q.push_back(8'h90); exp_q.push_back(8'h83); exp_q.push_back(8'h84); exp_q.push_back(8'h85);
        tick(1);
        RST = 1'b0;
        tick(1);
        check("mr_req0_wins", 32'(GRANT), 32'b0001);
        wait_drain("post_rst");

        // ptr now 1: requesters 1 and 2 together, 2 goes first.
        push(1, 8'hC1, 1'b1); push(2, 8'hC2, 1'b1);
        exp_q.push_back(8'hC2); exp_q.push_back(8'hC1);
        tick(1);
        check("skew_grant", 32'(GRANT), 32'b0100);
        wait_drain("skew");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
